// File: rtl/cyclone_pkg.sv
// Shared constants and state encoding for the heading-to-Cartesian CORDIC stage.
// Angles are integer microradians.
package cyclone_pkg;
  localparam logic signed [63:0] PI_URAD     = 64'sd3141593;
  localparam logic signed [63:0] PI_2_URAD   = 64'sd1570796;
  localparam logic signed [63:0] PI3_2_URAD  = 64'sd4712389;
  localparam logic signed [63:0] TWO_PI_URAD = 64'sd6283185;
  localparam int                 K_Q16       = 39797;

  typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_e;
endpackage

// File: rtl/cordic_atan_lut.sv
// atan(2^-i) in microradians, rounded to the nearest integer.
// Indices past the useful range return 0.
module cordic_atan_lut (
  input  logic [4:0]  idx,
  output logic [21:0] atan_urad
);
  always_comb begin
    atan_urad = 22'd0;
    case (idx)
      5'd0:  atan_urad = 22'd785398;
      5'd1:  atan_urad = 22'd463648;
      5'd2:  atan_urad = 22'd244979;
      5'd3:  atan_urad = 22'd124355;
      5'd4:  atan_urad = 22'd62419;
      5'd5:  atan_urad = 22'd31240;
      5'd6:  atan_urad = 22'd15624;
      5'd7:  atan_urad = 22'd7812;
      5'd8:  atan_urad = 22'd3906;
      5'd9:  atan_urad = 22'd1953;
      5'd10: atan_urad = 22'd977;
      5'd11: atan_urad = 22'd488;
      5'd12: atan_urad = 22'd244;
      5'd13: atan_urad = 22'd122;
      5'd14: atan_urad = 22'd61;
      5'd15: atan_urad = 22'd31;
      5'd16: atan_urad = 22'd15;
      5'd17: atan_urad = 22'd8;
      5'd18: atan_urad = 22'd4;
      5'd19: atan_urad = 22'd2;
      5'd20: atan_urad = 22'd1;
      default: atan_urad = 22'd0;
    endcase
  end
endmodule

// File: rtl/polar_to_cartesian.sv
// Iterative rotation-mode CORDIC: heading (urad) + radius -> x/y offsets,
// one micro-rotation per clock under a start/done handshake.
module polar_to_cartesian #(
  parameter int ITER  = 20,
  parameter int DW    = 48,
  parameter int K_Q16 = cyclone_pkg::K_Q16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [63:0] argument,
  input  logic [31:0]        radius,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic signed [63:0] x_out,
  output logic signed [63:0] y_out
);
  import cyclone_pkg::*;

  state_e                state_q, state_d;
  logic [4:0]            iter_q, iter_d;
  logic signed [63:0]    arg_q, arg_d;
  logic [31:0]           rad_q, rad_d;
  logic signed [DW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic                  neg_q, neg_d;
  logic signed [63:0]    x_out_q, x_out_d, y_out_q, y_out_d;
  logic                  range_err_q, range_err_d;

  logic                  arg_oor, neg_red, last_iter;
  logic signed [DW-1:0]  z_red, x0, atan_ext, x_sh, y_sh, x_n, y_n, z_n;
  logic [21:0]           atan_urad;

  cordic_atan_lut u_lut (.idx(iter_q), .atan_urad(atan_urad));

  assign last_iter = (iter_q == 5'(ITER - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      arg_q       <= '0;
      rad_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      neg_q       <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      arg_q       <= arg_d;
      rad_q       <= rad_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      range_err_q <= range_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = arg_oor ? DONE : ROT;
      ROT:  if (last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == LOAD) || (state_q == ROT);
    done      = (state_q == DONE);
    range_err = range_err_q;
    x_out     = x_out_q;
    y_out     = y_out_q;
  end

  // Fold the heading into [-pi/2, pi/2) so CORDIC converges; the pi shift
  // is undone by negating the result.
  always_comb begin
    arg_oor = (arg_q < 64'sd0) || (arg_q >= TWO_PI_URAD);
    neg_red = 1'b0;
    if (arg_q < PI_2_URAD) begin
      z_red = DW'(arg_q);
    end else if (arg_q < PI3_2_URAD) begin
      z_red   = DW'(arg_q - PI_URAD);
      neg_red = 1'b1;
    end else begin
      z_red = DW'(arg_q - TWO_PI_URAD);
    end
    x0 = DW'((48'(rad_q) * 48'(K_Q16)) >> 16);
  end

  always_comb begin
    atan_ext = DW'(atan_urad);
    x_sh     = x_q >>> iter_q;
    y_sh     = y_q >>> iter_q;
    if (!z_q[DW-1]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_ext;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_ext;
    end
  end

  always_comb begin
    iter_d      = iter_q;
    arg_d       = arg_q;
    rad_d       = rad_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    neg_d       = neg_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    range_err_d = range_err_q;
    case (state_q)
      IDLE: if (start) begin
        arg_d = argument;
        rad_d = radius;
      end
      LOAD: begin
        iter_d = '0;
        if (arg_oor) begin
          x_out_d     = '0;
          y_out_d     = '0;
          range_err_d = 1'b1;
        end else begin
          x_d   = x0;
          y_d   = '0;
          z_d   = z_red;
          neg_d = neg_red;
        end
      end
      ROT: begin
        x_d    = x_n;
        y_d    = y_n;
        z_d    = z_n;
        iter_d = iter_q + 5'd1;
        if (last_iter) begin
          iter_d      = '0;
          x_out_d     = 64'(neg_q ? -x_n : x_n);
          y_out_d     = 64'(neg_q ? -y_n : y_n);
          range_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_polar_to_cartesian.sv
// Self-checking bench: directed vector table, random vectors against a
// trig reference model, and handshake/reset corner sequences.
module tb_polar_to_cartesian;
  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [63:0] argument;
  logic [31:0]        radius;
  logic               busy, done, range_err;
  logic signed [63:0] x_out, y_out;

  int checks = 0;
  int errors = 0;

  polar_to_cartesian dut (
    .clk(clk), .reset(reset), .start(start), .argument(argument),
    .radius(radius), .busy(busy), .done(done), .range_err(range_err),
    .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint arg;
    longint rad;
    longint ex;
    longint ey;
    bit     err;
    int     lat;
    longint tol;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Launch one conversion from IDLE; returns results sampled in the done cycle.
  task automatic run(input longint a, input longint r, output longint xo, output longint yo,
                     output bit eo, output int lat);
    argument = a;
    radius   = 32'(r);
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (lat == 2) argument = {$urandom, $urandom};
    end
    xo = x_out;
    yo = y_out;
    eo = range_err;
    tick();
    check("done_one_cycle", longint'(done), 0, 0);
  endtask

  initial begin
    longint xo, yo, ex, ey, a, r;
    bit     eo;
    int     lat, nb, extra, nd, dc;
    real    ang;

    vecs[0]  = '{0,        1000000, 1000000,  0,        1'b0, 22, 32};
    vecs[1]  = '{1570796,  1000000, 0,        1000000,  1'b0, 22, 32};
    vecs[2]  = '{785398,   1000000, 707107,   707107,   1'b0, 22, 32};
    vecs[3]  = '{3141593,  1000000, -1000000, 0,        1'b0, 22, 32};
    vecs[4]  = '{4712389,  1000000, 0,        -1000000, 1'b0, 22, 32};
    vecs[5]  = '{6283184,  1000000, 1000000,  0,        1'b0, 22, 32};
    vecs[6]  = '{1000,     0,       0,        0,        1'b0, 22, 0};
    vecs[7]  = '{6283185,  1000000, 0,        0,        1'b1, 2,  0};
    vecs[8]  = '{-1,       1000000, 0,        0,        1'b1, 2,  0};
    vecs[9]  = '{1570795,  1000000, 0,        1000000,  1'b0, 22, 32};
    vecs[10] = '{4712388,  1000000, 0,        -1000000, 1'b0, 22, 32};

    reset = 1'b1; start = 1'b0; argument = '0; radius = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_range_err", longint'(range_err), 0, 0);
    check("rst_x", x_out, 0, 0);
    check("rst_y", y_out, 0, 0);

    foreach (vecs[i]) begin
      run(vecs[i].arg, vecs[i].rad, xo, yo, eo, lat);
      check($sformatf("vec%0d_lat", i), longint'(lat), longint'(vecs[i].lat), 0);
      check($sformatf("vec%0d_err", i), longint'(eo), longint'(vecs[i].err), 0);
      check($sformatf("vec%0d_x", i), xo, vecs[i].ex, vecs[i].tol);
      check($sformatf("vec%0d_y", i), yo, vecs[i].ey, vecs[i].tol);
    end

    for (int k = 0; k < 40; k++) begin
      a   = longint'($urandom_range(6283184, 0));
      r   = longint'($urandom_range(1000000, 0));
      ang = real'(a) * 1.0e-6;
      ex  = longint'(real'(r) * $cos(ang));
      ey  = longint'(real'(r) * $sin(ang));
      run(a, r, xo, yo, eo, lat);
      check($sformatf("rnd%0d_lat", k), longint'(lat), 22, 0);
      check($sformatf("rnd%0d_err", k), longint'(eo), 0, 0);
      check($sformatf("rnd%0d_x a=%0d r=%0d", k, a, r), xo, ex, 32);
      check($sformatf("rnd%0d_y a=%0d r=%0d", k, a, r), yo, ey, 32);
    end

    // Results hold after the done pulse.
    run(785398, 1000000, xo, yo, eo, lat);
    tick(); tick(); tick();
    check("hold_done", longint'(done), 0, 0);
    check("hold_x", x_out, 707107, 32);
    check("hold_y", y_out, 707107, 32);

    // Start pulses mid-rotation and during DONE are ignored.
    argument = 785398; radius = 1000000; start = 1'b1;
    check("seq_busy_c0", longint'(busy), 0, 0);
    nb = 0; extra = 0; nd = 0; dc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = (c == 5 || c == 22);
      if (busy && c <= 21) nb++;
      if (busy && c > 21) extra++;
      if (done) begin nd++; dc = c; end
    end
    start = 1'b0;
    check("seq_busy_cycles", longint'(nb), 21, 0);
    check("seq_busy_extra", longint'(extra), 0, 0);
    check("seq_done_count", longint'(nd), 1, 0);
    check("seq_done_cycle", longint'(dc), 22, 0);

    // Reset mid-conversion aborts without a done pulse.
    argument = 0; radius = 1000000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", longint'(busy), 0, 0);
    check("abort_done", longint'(done), 0, 0);
    check("abort_x", x_out, 0, 0);
    check("abort_y", y_out, 0, 0);
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", longint'(nd), 0, 0);
    run(0, 1000000, xo, yo, eo, lat);
    check("post_abort_lat", longint'(lat), 22, 0);
    check("post_abort_x", xo, 1000000, 32);
    check("post_abort_y", yo, 0, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
